my_if_driver: RTL and testbench
===============================

# my_if_driver

Slave-side driver for `my_interface`. It accepts select/field commands over a valid/ready port and buffers them in a small FIFO. It then drives `sel`, `field0` and `field1` on the interface, holding each command for a programmed number of clock-enabled cycles. It sits opposite the interface master: the master consumes these signals, and this block produces them under test or firmware control.

## Interface
- `DEPTH`, 4: command FIFO depth, power of two, ≥2
- `clk`  in  1  clock
- `rst_n`  in  1  reset; one clock, asynchronous, active-low
- `clk_en`  in  1  clock enable; hold counting advances only when high
- `flush`  in  1  synchronous flush of FIFO and active command
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  FIFO can accept; equals not-full
- `cmd_sel`  in  5  select value to drive
- `cmd_field0`, `cmd_field1`  in  1 each  field flags to drive
- `cmd_hold`  in  4  drive duration, in enabled cycles, minus one
- `my_if`  `my_interface.slave`  —  drives `sel[4:0]`, `field0`, `field1`
- `busy`  out  1  a command is being driven
- `done`  out  1  one-cycle pulse when the last queued command finishes
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- Push rule: a command is pushed when `cmd_valid && cmd_ready`.
- `clk_en` gating:
  - `clk_en` does not gate pushes.
  - Pops and hold-counter decrements occur only in cycles with `clk_en`=1.
- FSM states:
  - IDLE: interface driven to 0/0/0, `busy`=0.
  - DRIVE: registered command on interface, `busy`=1.
- IDLE→DRIVE:
  - Transition occurs when FIFO is non-empty and `clk_en`=1.
  - The head entry is popped and registered.
  - `cnt` is loaded with `cmd_hold`.
- DRIVE behaviour:
  - On each `clk_en` cycle with `cnt`≠0, `cnt` decrements.
  - When `cnt`=0 and `clk_en`=1 with the FIFO non-empty, the next command is popped and loaded in the same edge, with no idle gap. State stays DRIVE.
  - When `cnt`=0 and `clk_en`=1 with the FIFO empty, the state goes to IDLE, the outputs return to 0, and `done` pulses on that same edge.
- Push and pop in the same cycle are both honoured; `level` is unchanged.
- Pushes are not possible while full, because `cmd_ready`=0.
- Push while empty and idle: the earliest pop is the next `clk_en` cycle after the push edge. There is no FIFO bypass.
- `flush` (priority over everything except reset):
  - Empties the FIFO and forces IDLE.
  - Outputs return to 0 and `done` stays 0.
  - A push in the same cycle is discarded.
- Asynchronous reset mid-operation: immediate return to IDLE, FIFO emptied, all outputs at reset values.
- Width rules:
  - `level` saturates naturally at DEPTH.
  - FIFO pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.

## Timing
Reset values:

| Output | Reset value |
|---|---|
| `my_if.sel` | 0 |
| `field0` | 0 |
| `field1` | 0 |
| `busy` | 0 |
| `done` | 0 |
| `level` | 0 |
| `cmd_ready` | 1 |

All outputs are registered except `cmd_ready`, which is decoded from the registered `level`.

Latency and timing, with `clk_en` held high:
- Push at edge N, into an empty FIFO while idle: interface shows the command after edge N+1.
- A command with hold H occupies the interface for exactly H+1 enabled cycles.
- `clk_en` low freezes the counter and the FSM, and the interface holds its value.
- `done` is high for exactly one cycle.
- `done` is not emitted after a flush or a reset.

## Structure
Package `my_if_pkg` holds:
- typedef `my_if_cmd_t`, a packed struct: `sel[4:0]`, `field0`, `field1`, `hold[3:0]`.
- enum `my_if_drv_state_e` with values IDLE and DRIVE.
- localparam `MY_IF_SEL_W`=5.

Sub-module `my_if_cmd_fifo`:
- A synchronous FIFO of `my_if_cmd_t`.
- Parameterised by DEPTH.
- Ports: push/pop/flush/full/empty/level.

The top level contains the FSM, the hold counter and the interface output registers.

## Test plan
1. Reset, then push {sel=16, f0=1, f1=0, hold=0} with `clk_en`=1 → `sel`=16 for 1 cycle, then 0. `done` pulses on the return to 0 and `level` goes 1→0.
2. Push {7, hold=2} and {3, hold=1} back-to-back → `sel`=7 for 3 cycles, then 3 for 2 cycles with no gap. `done` fires once, at the end.
3. Push 4 commands without popping (`clk_en`=0) → `level`=4 and `cmd_ready`=0. A 5th offer is not accepted. Raise `clk_en` → all 4 commands are driven in order.
4. Drive {4, hold=5} and toggle `clk_en` low for 3 cycles mid-hold → `sel`=4 for 9 total cycles (6 enabled + 3 frozen).
5. Assert `flush` while `busy` with `level`=2 → next cycle `sel`=0, `busy`=0, `level`=0, and no `done`.
6. Drop `rst_n` mid-DRIVE asynchronously → outputs are 0 before the next clock edge. After release, the block accepts new commands normally.

Source files
------------

// File: rtl/my_if_pkg.sv
// Shared types for the my_interface slave-side driver: command record,
// FSM state encoding and select width.
package my_if_pkg;

    localparam int MY_IF_SEL_W  = 5;
    localparam int MY_IF_HOLD_W = 4;

    typedef struct packed {
        logic [MY_IF_SEL_W-1:0]  sel;
        logic                    field0;
        logic                    field1;
        logic [MY_IF_HOLD_W-1:0] hold;
    } my_if_cmd_t;

    typedef enum logic {
        IDLE  = 1'b0,
        DRIVE = 1'b1
    } my_if_drv_state_e;

endpackage

// File: rtl/my_if_driver_if.sv
// my_interface: select/field bundle. The driver owns the slave modport and
// produces the signals; the master modport consumes them.
interface my_interface;
    import my_if_pkg::*;

    logic [MY_IF_SEL_W-1:0] sel;
    logic                   field0;
    logic                   field1;

    modport master (input  sel, field0, field1);
    modport slave  (output sel, field0, field1);

endinterface

// File: rtl/my_if_cmd_fifo.sv
// Command FIFO for the driver: registered occupancy, head visible
// combinationally, flush beats both push and pop.
module my_if_cmd_fifo
    import my_if_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  my_if_cmd_t       push_data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output my_if_cmd_t       head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LVL_W-1:0] level_o
);

    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    my_if_cmd_t       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (level_q == FULL_LVL);
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign push_ok = push_i && !full_o && !flush_i;
    assign pop_ok  = pop_i && !empty_o && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({push_ok, pop_ok})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage carries data only; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/my_if_driver.sv
// Slave-side driver for my_interface: queues select/field commands and plays
// each one onto the interface for (hold+1) clock-enabled cycles.
module my_if_driver
    import my_if_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clk_en,
    input  logic                    flush,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [MY_IF_SEL_W-1:0]  cmd_sel,
    input  logic                    cmd_field0,
    input  logic                    cmd_field1,
    input  logic [MY_IF_HOLD_W-1:0] cmd_hold,
    my_interface.slave              my_if,
    output logic                    busy,
    output logic                    done,
    output logic [LVL_W-1:0]        level
);

    my_if_drv_state_e        state_q;
    logic [MY_IF_SEL_W-1:0]  sel_q;
    logic                    field0_q;
    logic                    field1_q;
    logic [MY_IF_HOLD_W-1:0] cnt_q;
    logic                    busy_q;
    logic                    done_q;

    my_if_cmd_t push_cmd;
    my_if_cmd_t head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       pop;

    assign push_cmd = '{sel: cmd_sel, field0: cmd_field0, field1: cmd_field1, hold: cmd_hold};

    // A pop is a load: from IDLE, or when the active command's hold expires.
    assign pop = clk_en && !flush && !fifo_empty &&
                 ((state_q == IDLE) || (cnt_q == '0));

    my_if_cmd_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (cmd_valid),
        .push_data_i (push_cmd),
        .pop_i       (pop),
        .flush_i     (flush),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .level_o     (level)
    );

    assign cmd_ready = !fifo_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            field0_q <= 1'b0;
            field1_q <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (flush) begin
                state_q  <= IDLE;
                sel_q    <= '0;
                field0_q <= 1'b0;
                field1_q <= 1'b0;
                cnt_q    <= '0;
                busy_q   <= 1'b0;
            end else if (pop) begin
                state_q  <= DRIVE;
                sel_q    <= head.sel;
                field0_q <= head.field0;
                field1_q <= head.field1;
                cnt_q    <= head.hold;
                busy_q   <= 1'b1;
            end else if (clk_en) begin
                case (state_q)
                    DRIVE: begin
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - MY_IF_HOLD_W'(1);
                        end else begin
                            // Queue drained: release the bus and flag completion.
                            state_q  <= IDLE;
                            sel_q    <= '0;
                            field0_q <= 1'b0;
                            field1_q <= 1'b0;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign my_if.sel    = sel_q;
    assign my_if.field0 = field0_q;
    assign my_if.field1 = field1_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_my_if_driver.sv
// Bench for my_if_driver: directed scenarios with a scoreboard of expected
// commands, matched against runs observed on the interface.
module tb_my_if_driver;
    import my_if_pkg::*;

    localparam int DEPTH = 4;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    clk_en = 1'b0;
    logic                    flush = 1'b0;
    logic                    cmd_valid = 1'b0;
    logic                    cmd_ready;
    logic [MY_IF_SEL_W-1:0]  cmd_sel = '0;
    logic                    cmd_field0 = 1'b0;
    logic                    cmd_field1 = 1'b0;
    logic [MY_IF_HOLD_W-1:0] cmd_hold = '0;
    logic                    busy;
    logic                    done;
    logic [LVL_W-1:0]        level;

    my_interface mif ();

    my_if_driver #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk_en     (clk_en),
        .flush      (flush),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_sel    (cmd_sel),
        .cmd_field0 (cmd_field0),
        .cmd_field1 (cmd_field1),
        .cmd_hold   (cmd_hold),
        .my_if      (mif),
        .busy       (busy),
        .done       (done),
        .level      (level)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard: commands expected on the interface, in order.
    my_if_cmd_t exp_q[$];
    bit         discard = 1'b0;
    int         done_cnt = 0;
    bit         run_active = 1'b0;
    logic [6:0] run_val = '0;
    int         run_en = 0;
    int         run_all = 0;
    int         last_all = 0;

    always @(negedge clk) begin
        logic [6:0] cur;
        my_if_cmd_t e;
        cur = {mif.sel, mif.field0, mif.field1};
        if (done) done_cnt++;
        if (run_active && (!busy || cur != run_val)) begin
            run_active = 1'b0;
            last_all   = run_all;
            if (!discard) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_cmd", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_cmd", int'(run_val), int'({e.sel, e.field0, e.field1}));
                    chk("sb_hold_cycles", run_en, int'(e.hold) + 1);
                end
            end
        end
        if (busy && !run_active) begin
            run_active = 1'b1;
            run_val    = cur;
            run_en     = 0;
            run_all    = 0;
        end
        if (run_active) begin
            run_all++;
            if (clk_en) run_en++;
        end
    end

    // Offer one command for one edge; it is expected only if accepted.
    task automatic push_cmd(input logic [4:0] s, input logic f0, input logic f1,
                            input logic [3:0] h, output bit acc);
        cmd_valid  = 1'b1;
        cmd_sel    = s;
        cmd_field0 = f0;
        cmd_field1 = f1;
        cmd_hold   = h;
        @(negedge clk);
        acc = cmd_ready && !flush;
        if (acc) exp_q.push_back('{sel: s, field0: f0, field1: f1, hold: h});
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || level != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", int'(n < 300), 1);
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit acc;
        int d0;

        // Reset values
        #12;
        chk("rst_sel", mif.sel, 0);
        chk("rst_f0", mif.field0, 0);
        chk("rst_f1", mif.field1, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_level", level, 0);
        chk("rst_ready", cmd_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: single command, hold 0
        clk_en = 1'b1;
        d0 = done_cnt;
        push_cmd(5'd16, 1'b1, 1'b0, 4'd0, acc);
        chk("t1_level_after_push", level, 1);
        chk("t1_no_bypass", busy, 0);
        @(posedge clk);
        #1;
        chk("t1_sel_shown", mif.sel, 16);
        chk("t1_f0_shown", mif.field0, 1);
        chk("t1_level_popped", level, 0);
        @(posedge clk);
        #1;
        chk("t1_sel_back_0", mif.sel, 0);
        chk("t1_done_pulse", done, 1);
        wait_idle();
        chk("t1_done_count", done_cnt - d0, 1);

        // 2: two commands back-to-back, no gap, one done
        d0 = done_cnt;
        push_cmd(5'd7, 1'b0, 1'b1, 4'd2, acc);
        push_cmd(5'd3, 1'b1, 1'b1, 4'd1, acc);
        wait_idle();
        chk("t2_done_count", done_cnt - d0, 1);

        // 3: fill with clk_en low, fifth offer refused, then drain in order
        clk_en = 1'b0;
        d0 = done_cnt;
        push_cmd(5'd1, 1'b0, 0, 4'd0, acc);
        push_cmd(5'd2, 1'b1, 0, 4'd1, acc);
        push_cmd(5'd5, 1'b0, 1, 4'd2, acc);
        push_cmd(5'd9, 1'b1, 1, 4'd3, acc);
        chk("t3_level_full", level, 4);
        chk("t3_ready_low", cmd_ready, 0);
        push_cmd(5'd31, 1'b1, 1, 4'd0, acc);
        chk("t3_fifth_refused", acc, 0);
        chk("t3_level_still_full", level, 4);
        clk_en = 1'b1;
        wait_idle();
        chk("t3_done_count", done_cnt - d0, 1);

        // 4: hold 5 with clk_en low for 3 cycles mid-hold
        push_cmd(5'd4, 1'b0, 1'b1, 4'd5, acc);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        clk_en = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("t4_frozen_sel", mif.sel, 4);
        end
        clk_en = 1'b1;
        wait_idle();
        chk("t4_total_cycles", last_all, 9);

        // 5: flush while busy with two queued, concurrent push dropped
        clk_en = 1'b0;
        d0 = done_cnt;
        push_cmd(5'd11, 1'b1, 0, 4'd3, acc);
        push_cmd(5'd12, 1'b0, 1, 4'd3, acc);
        push_cmd(5'd13, 1'b1, 1, 4'd3, acc);
        clk_en = 1'b1;
        @(posedge clk);
        #1;
        clk_en = 1'b0;
        chk("t5_busy", busy, 1);
        chk("t5_level_2", level, 2);
        discard   = 1'b1;
        flush     = 1'b1;
        cmd_valid = 1'b1;
        cmd_sel   = 5'd30;
        @(posedge clk);
        #1;
        flush     = 1'b0;
        cmd_valid = 1'b0;
        chk("t5_sel_0", mif.sel, 0);
        chk("t5_busy_0", busy, 0);
        chk("t5_level_0", level, 0);
        chk("t5_done_0", done, 0);
        clk_en = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_done_still_0", done, 0);
        chk("t5_push_dropped", level, 0);
        exp_q.delete();
        discard = 1'b0;
        chk("t5_done_count", done_cnt - d0, 0);

        // 6: asynchronous reset mid-drive, then normal operation
        d0 = done_cnt;
        push_cmd(5'd21, 1'b1, 1'b1, 4'd7, acc);
        @(posedge clk);
        #1;
        chk("t6_busy", busy, 1);
        discard = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_sel", mif.sel, 0);
        chk("t6_async_f0", mif.field0, 0);
        chk("t6_async_f1", mif.field1, 0);
        chk("t6_async_busy", busy, 0);
        chk("t6_async_level", level, 0);
        chk("t6_async_ready", cmd_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        discard = 1'b0;
        chk("t6_no_done_after_reset", done_cnt - d0, 0);
        d0 = done_cnt;
        push_cmd(5'd2, 1'b0, 1'b1, 4'd1, acc);
        chk("t6_accepted", acc, 1);
        wait_idle();
        chk("t6_done_count", done_cnt - d0, 1);

        chk("sb_leftover", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
